// File: rtl/l2_sio_pkg.sv
// Shared constants, receive FSM states and the assembled packet record for the
// L2-to-SIO response receiver.
package l2_sio_pkg;

  localparam int DATA_W           = 32;
  localparam int L2_SIO_NUM_BEATS = 16;
  localparam int PKT_DATA_W       = DATA_W * L2_SIO_NUM_BEATS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } rcv_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     hdr;
    logic [PKT_DATA_W-1:0] data;
    logic                  par_err;
    logic                  ue_err;
  } sio_pkt_t;

endpackage

// File: rtl/l2_sio_rsp_buf.sv
// Small valid/ready FIFO of assembled packets; a pop in the same cycle frees
// room for a push, so push and pop together on a full buffer both succeed.
module l2_sio_rsp_buf
  import l2_sio_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     in_vld,
  output logic     in_rdy,
  input  sio_pkt_t in_pkt,
  output logic     out_vld,
  input  logic     out_rdy,
  output sio_pkt_t out_pkt
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  sio_pkt_t         mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;

  assign out_vld = (count_q != '0);
  assign pop     = out_vld && out_rdy;
  assign in_rdy  = (count_q != FULL_CNT) || pop;
  assign push    = in_vld && in_rdy;
  assign out_pkt = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is data only; occupancy is tracked by the reset pointers above.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_pkt;
  end

endmodule

// File: rtl/l2_sio_rsp_rcv.sv
// Assembles L2 response packets (header + NUM_BEATS data beats, NUM_BEATS up to
// L2_SIO_NUM_BEATS) and buffers them; parity checking with L2_SIO_RCV_PAR_CHK_EN.
module l2_sio_rsp_rcv
  import l2_sio_pkg::*;
#(
  parameter int NUM_BEATS = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic                        iol2clk,
  input  logic                        reset,
  input  logic                        l2b_sio_ctag_vld,
  input  logic [DATA_W-1:0]           l2b_sio_data,
  input  logic [1:0]                  l2b_sio_parity,
  input  logic                        l2b_sio_ue_err,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [DATA_W-1:0]           out_hdr,
  output logic [DATA_W*NUM_BEATS-1:0] out_data,
  output logic                        out_par_err,
  output logic                        out_ue_err,
  output logic                        ovf_err,
  output logic                        proto_err
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  rcv_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic hdr_start, beat_wr, commit;
  logic drop_q, ovf_q, proto_q;
  logic beat_par_err;

  logic [DATA_W-1:0]                hdr_p0;
  logic [NUM_BEATS-1:0][DATA_W-1:0] data_p0;
  logic [NUM_BEATS-1:0][DATA_W-1:0] data_merged;
  logic                             par_acc_p0, ue_acc_p0;

  sio_pkt_t push_pkt, head_pkt;
  logic     push_vld, buf_in_rdy;

`ifdef L2_SIO_RCV_PAR_CHK_EN
  // Even parity per half-word: the expected bit is the XOR of its 16 bits.
  function automatic logic [1:0] par_calc(input logic [DATA_W-1:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  assign beat_par_err = |(l2b_sio_parity ^ par_calc(l2b_sio_data));
`else
  logic unused_parity;
  assign unused_parity = ^l2b_sio_parity;
  assign beat_par_err  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_start = 1'b0;
    beat_wr   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (l2b_sio_ctag_vld) begin
          hdr_start = 1'b1;
          cnt_d     = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (l2b_sio_ctag_vld) begin
          // A header mid-packet abandons the partial packet and restarts.
          hdr_start = 1'b1;
          cnt_d     = '0;
        end else begin
          beat_wr = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            commit  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iol2clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      proto_q <= (state_q == ST_DATA) && l2b_sio_ctag_vld;
      if (hdr_start) begin
        drop_q <= !buf_in_rdy;
        ovf_q  <= ovf_q | !buf_in_rdy;
      end
    end
  end

  // Stage p0: header and data beat capture with error accumulation.
  always_ff @(posedge iol2clk) begin
    if (hdr_start) begin
      hdr_p0     <= l2b_sio_data;
      par_acc_p0 <= beat_par_err;
      ue_acc_p0  <= l2b_sio_ue_err;
    end else if (beat_wr) begin
      data_p0[cnt_q] <= l2b_sio_data;
      par_acc_p0     <= par_acc_p0 | beat_par_err;
      ue_acc_p0      <= ue_acc_p0 | l2b_sio_ue_err;
    end
  end

  // The last beat bypasses the p0 store so the packet is pushed in its own cycle.
  always_comb begin
    data_merged                = data_p0;
    data_merged[NUM_BEATS-1]   = l2b_sio_data;
    push_pkt.hdr               = hdr_p0;
    push_pkt.data              = PKT_DATA_W'(data_merged);
    push_pkt.par_err           = par_acc_p0 | beat_par_err;
    push_pkt.ue_err            = ue_acc_p0 | l2b_sio_ue_err;
  end

  assign push_vld = commit && !drop_q;

  l2_sio_rsp_buf #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk     (iol2clk),
    .reset   (reset),
    .in_vld  (push_vld),
    .in_rdy  (buf_in_rdy),
    .in_pkt  (push_pkt),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_pkt (head_pkt)
  );

  // Outputs read zero whenever nothing is buffered, so buffer storage needs no reset.
  assign out_hdr     = out_vld ? head_pkt.hdr : '0;
  assign out_data    = out_vld ? head_pkt.data[DATA_W*NUM_BEATS-1:0] : '0;
  assign out_par_err = out_vld & head_pkt.par_err;
  assign out_ue_err  = out_vld & head_pkt.ue_err;
  assign ovf_err     = ovf_q;
  assign proto_err   = proto_q;

endmodule

// File: tb/tb_l2_sio_rsp_rcv.sv
// Directed bench for l2_sio_rsp_rcv: assembly, error flags, overflow, protocol
// error and mid-packet reset, using the default NUM_BEATS=16 / BUF_DEPTH=2.
module tb_l2_sio_rsp_rcv;

  logic         iol2clk = 1'b0;
  logic         reset = 1'b1;
  logic         l2b_sio_ctag_vld = 1'b0;
  logic [31:0]  l2b_sio_data = '0;
  logic [1:0]   l2b_sio_parity = '0;
  logic         l2b_sio_ue_err = 1'b0;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic [31:0]  out_hdr;
  logic [511:0] out_data;
  logic         out_par_err;
  logic         out_ue_err;
  logic         ovf_err;
  logic         proto_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 iol2clk = ~iol2clk;

  l2_sio_rsp_rcv dut (
    .iol2clk          (iol2clk),
    .reset            (reset),
    .l2b_sio_ctag_vld (l2b_sio_ctag_vld),
    .l2b_sio_data     (l2b_sio_data),
    .l2b_sio_parity   (l2b_sio_parity),
    .l2b_sio_ue_err   (l2b_sio_ue_err),
    .out_vld          (out_vld),
    .out_rdy          (out_rdy),
    .out_hdr          (out_hdr),
    .out_data         (out_data),
    .out_par_err      (out_par_err),
    .out_ue_err       (out_ue_err),
    .ovf_err          (ovf_err),
    .proto_err        (proto_err)
  );

  function automatic logic [1:0] even_par(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  // One L2 cycle, driven on the falling edge.
  task automatic beat(input logic ctag, input logic [31:0] d, input logic flip1, input logic ue);
    @(negedge iol2clk);
    l2b_sio_ctag_vld = ctag;
    l2b_sio_data     = d;
    l2b_sio_parity   = even_par(d) ^ {flip1, 1'b0};
    l2b_sio_ue_err   = ue;
  endtask

  task automatic idle();
    beat(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] base,
                          input int flip_beat, input int ue_beat);
    beat(1'b1, hdr, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      beat(1'b0, base + 32'(i), (i == flip_beat), (i == ue_beat));
  endtask

  task automatic pop_one();
    @(negedge iol2clk);
    out_rdy = 1'b1;
    @(negedge iol2clk);
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) idle();
    reset = 1'b0;
    idle();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %0b want 0", out_vld); end
    n_cmp++; if (out_hdr !== 32'h0) begin n_err++; $display("FAIL rst_hdr: got %h want 0", out_hdr); end
    n_cmp++; if (out_data !== 512'h0) begin n_err++; $display("FAIL rst_data: got nonzero want 0"); end
    n_cmp++; if ({out_par_err, out_ue_err, ovf_err, proto_err} !== 4'b0)
      begin n_err++; $display("FAIL rst_flags: got %b want 0000", {out_par_err, out_ue_err, ovf_err, proto_err}); end
  endtask

  task automatic test_basic();
    send_pkt(32'h0000_1234, 32'h0, -1, -1);
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL basic_early_vld: got %0b want 0", out_vld); end
    idle();
    n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld: got %0b want 1", out_vld); end
    n_cmp++; if (out_hdr !== 32'h0000_1234) begin n_err++; $display("FAIL basic_hdr: got %h want 00001234", out_hdr); end
    n_cmp++; if (out_data[31:0] !== 32'h0) begin n_err++; $display("FAIL basic_beat0: got %h want 0", out_data[31:0]); end
    n_cmp++; if (out_data[255:224] !== 32'h7) begin n_err++; $display("FAIL basic_beat7: got %h want 7", out_data[255:224]); end
    n_cmp++; if (out_data[511:480] !== 32'hF) begin n_err++; $display("FAIL basic_beat15: got %h want f", out_data[511:480]); end
    n_cmp++; if ({out_par_err, out_ue_err} !== 2'b00) begin n_err++; $display("FAIL basic_errs: got %b want 00", {out_par_err, out_ue_err}); end
    repeat (2) idle();
    n_cmp++; if (out_hdr !== 32'h0000_1234) begin n_err++; $display("FAIL basic_hold: got %h want 00001234", out_hdr); end
    pop_one();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL basic_popped: got %0b want 0", out_vld); end
  endtask

  task automatic test_parity();
    logic exp_par;
`ifdef L2_SIO_RCV_PAR_CHK_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    send_pkt(32'h0000_00A5, 32'h1357_0000, 5, -1);
    idle();
    n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL par_vld: got %0b want 1", out_vld); end
    n_cmp++; if (out_par_err !== exp_par) begin n_err++; $display("FAIL par_err: got %0b want %0b", out_par_err, exp_par); end
    n_cmp++; if (out_ue_err !== 1'b0) begin n_err++; $display("FAIL par_ue: got %0b want 0", out_ue_err); end
    n_cmp++; if (out_data[191:160] !== 32'h1357_0005) begin n_err++; $display("FAIL par_beat5: got %h want 13570005", out_data[191:160]); end
    pop_one();
  endtask

  task automatic test_ue();
    send_pkt(32'h0000_0BEE, 32'hCAFE_0100, -1, 15);
    idle();
    n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL ue_vld: got %0b want 1", out_vld); end
    n_cmp++; if (out_ue_err !== 1'b1) begin n_err++; $display("FAIL ue_err: got %0b want 1", out_ue_err); end
    n_cmp++; if (out_par_err !== 1'b0) begin n_err++; $display("FAIL ue_par: got %0b want 0", out_par_err); end
    n_cmp++; if (out_data[31:0] !== 32'hCAFE_0100) begin n_err++; $display("FAIL ue_beat0: got %h want cafe0100", out_data[31:0]); end
    n_cmp++; if (out_data[511:480] !== 32'hCAFE_010F) begin n_err++; $display("FAIL ue_beat15: got %h want cafe010f", out_data[511:480]); end
    pop_one();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL ue_popped: got %0b want 0", out_vld); end
  endtask

  task automatic test_overflow();
    send_pkt(32'h1, 32'h100, -1, -1);
    send_pkt(32'h2, 32'h200, -1, -1);
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %0b want 0", ovf_err); end
    send_pkt(32'h3, 32'h300, -1, -1);
    repeat (2) idle();
    n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b want 1", ovf_err); end
    n_cmp++; if (out_hdr !== 32'h1) begin n_err++; $display("FAIL ovf_first_hdr: got %h want 1", out_hdr); end
    n_cmp++; if (out_data[31:0] !== 32'h100) begin n_err++; $display("FAIL ovf_first_data: got %h want 100", out_data[31:0]); end
    pop_one();
    n_cmp++; if (out_hdr !== 32'h2) begin n_err++; $display("FAIL ovf_second_hdr: got %h want 2", out_hdr); end
    n_cmp++; if (out_data[511:480] !== 32'h20F) begin n_err++; $display("FAIL ovf_second_data: got %h want 20f", out_data[511:480]); end
    pop_one();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %0b want 0", out_vld); end
    n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b want 1", ovf_err); end
  endtask

  task automatic test_proto();
    beat(1'b1, 32'hA, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) beat(1'b0, 32'h20 + 32'(i), 1'b0, 1'b0);
    beat(1'b1, 32'hB, 1'b0, 1'b0);
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_pre: got %0b want 0", proto_err); end
    beat(1'b0, 32'h300, 1'b0, 1'b0);
    n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_pulse: got %0b want 1", proto_err); end
    beat(1'b0, 32'h301, 1'b0, 1'b0);
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_one_cycle: got %0b want 0", proto_err); end
    for (int i = 2; i < 16; i++) beat(1'b0, 32'h300 + 32'(i), 1'b0, 1'b0);
    idle();
    n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL proto_vld: got %0b want 1", out_vld); end
    n_cmp++; if (out_hdr !== 32'hB) begin n_err++; $display("FAIL proto_hdr: got %h want b", out_hdr); end
    n_cmp++; if (out_data[31:0] !== 32'h300) begin n_err++; $display("FAIL proto_beat0: got %h want 300", out_data[31:0]); end
    n_cmp++; if (out_data[511:480] !== 32'h30F) begin n_err++; $display("FAIL proto_beat15: got %h want 30f", out_data[511:480]); end
    pop_one();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL proto_single: got %0b want 0", out_vld); end
  endtask

  task automatic test_reset_mid();
    beat(1'b1, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) beat(1'b0, 32'h40 + 32'(i), 1'b0, 1'b0);
    @(negedge iol2clk);
    reset = 1'b1;
    l2b_sio_data = 32'h44;
    @(negedge iol2clk);
    reset = 1'b0;
    for (int i = 5; i < 16; i++) beat(1'b0, 32'h40 + 32'(i), 1'b0, 1'b0);
    repeat (3) idle();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rmid_vld: got %0b want 0", out_vld); end
    n_cmp++; if (out_hdr !== 32'h0) begin n_err++; $display("FAIL rmid_hdr: got %h want 0", out_hdr); end
    n_cmp++; if (out_data !== 512'h0) begin n_err++; $display("FAIL rmid_data: got nonzero want 0"); end
    n_cmp++; if ({out_par_err, out_ue_err, ovf_err, proto_err} !== 4'b0)
      begin n_err++; $display("FAIL rmid_flags: got %b want 0000", {out_par_err, out_ue_err, ovf_err, proto_err}); end
    send_pkt(32'h77, 32'h700, -1, -1);
    idle();
    n_cmp++; if (out_hdr !== 32'h77) begin n_err++; $display("FAIL rmid_recover: got %h want 77", out_hdr); end
    n_cmp++; if (out_data[511:480] !== 32'h70F) begin n_err++; $display("FAIL rmid_recover_data: got %h want 70f", out_data[511:480]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_ue();
    test_overflow();
    test_proto();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
